regfile_writeback_ctrl: RTL and testbench
=========================================

Name: regfile_writeback_ctrl

Overview:
- Write-side master for the 2R/1W register file.
- Merges two writeback sources into the file's single synchronous write port (we, A3, WD3):
  - the fixed-latency ALU, which has no backpressure;
  - the variable-latency LSU, which uses a valid/ready handshake.
- Keeps a per-register busy scoreboard and gives the issue stage a RAW/WAW stall, so reads from the asynchronous read ports never return stale data.

Parameters:
- ADDR_WIDTH, 5, register address width; the file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width.
- LSU_FIFO_DEPTH, 2, number of LSU writeback buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- iss_valid  in  1  issue stage presents an instruction
- iss_rs1  in  ADDR_WIDTH  source register 1
- iss_rs2  in  ADDR_WIDTH  source register 2
- iss_rd  in  ADDR_WIDTH  destination register to reserve
- iss_stall  out  1  hazard; the instruction must be held
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_WIDTH  ALU destination
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU buffer can accept
- lsu_rd  in  ADDR_WIDTH  LSU destination
- lsu_data  in  DATA_WIDTH  load data
- rf_we  out  1  register file write enable (to we)
- rf_waddr  out  ADDR_WIDTH  write address (to A3)
- rf_wdata  out  DATA_WIDTH  write data (to WD3)
- busy  out  2**ADDR_WIDTH  scoreboard; bit i set means register i has a write pending

Behaviour:
- Reset (rst_n low at a rising edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, FIFO emptied.
  - lsu_ready=0 and iss_stall=0 while rst_n is low.
  - Asserting reset mid-operation discards any buffered LSU entries; no write is issued for them.
- Register x0 is never written and never reserved.
  - A request with rd=0 is consumed and dropped: no rf_we, no scoreboard change.
  - busy[0] is always 0.
- Write port outputs are registered.
  - The winner selected in cycle N drives rf_we/rf_waddr/rf_wdata high and valid during cycle N+1.
  - The register file commits the write at the end of cycle N+1.
  - rf_we is a single-cycle pulse per write.
- Arbitration: ALU has fixed priority.
  - alu_valid with alu_rd!=0 always wins cycle N.
  - The FIFO head is written only in cycles with no ALU write.
  - An ALU-to-x0 request does not block the FIFO.
- LSU path:
  - An entry is pushed when lsu_valid && lsu_ready at a rising edge.
  - lsu_ready = !full; there is no pass-through on pop-when-full.
  - Minimum LSU latency: push at edge ending cycle N, head visible in N+1, rf_we high in N+2.
  - Entries drain in FIFO order.
  - Simultaneous push and pop updates the count by 0.
  - The LSU may starve while ALU writes are back-to-back. This is allowed; the pipeline guarantees gaps.
- Scoreboard:
  - Set: busy[iss_rd] is set at an edge where iss_valid && !iss_stall && iss_rd!=0.
  - Clear: busy[rf_waddr] is cleared at an edge where rf_we=1.
  - If set and clear hit the same index at the same edge, set wins.
  - An ALU/LSU write to a non-busy register is still performed and does not alter busy.
- Stall:
  - iss_stall = iss_valid && (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]).
  - Combinational from registered busy only; x0 terms are always 0.
  - There is no bypass. An instruction whose source is being committed in the current cycle stalls one more cycle and then reads the updated file.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined:
  - Adds output perf_stall_cycles[31:0], incremented each cycle iss_stall=1.
  - Adds output perf_lsu_bp_cycles[31:0], incremented each cycle lsu_valid && !lsu_ready.
  - Both counters wrap at 2**32 and reset to 0.
- Undefined: neither port nor the counter logic exists. All other behaviour is identical.

Test Plan:
- Reset, then alu_valid with alu_rd=5, alu_data=0xDEADBEEF in cycle 1 -> in cycle 2: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; in cycle 3: rf_we=0.
- Issue rd=7 (iss_valid, busy clear) -> busy[7]=1. Next issue has rs1=7 -> iss_stall=1. ALU write to 7 -> busy[7]=0 after the rf_we cycle, and iss_stall=0 the following cycle.
- LSU pushes rd=3/0x11 then rd=4/0x22 while alu_valid is held high to rd=9 for 4 cycles -> lsu_ready=0 after 2 pushes. After ALU stops: writes to 3 then 4, one per cycle.
- alu_rd=0 with alu_valid and a FIFO head rd=2 in the same cycle -> no write to x0; the rd=2 write appears the next cycle.
- Same edge: rf_we commits rd=6 while issue reserves rd=6 -> busy[6] remains 1.
- rst_n low for one cycle with 2 LSU entries buffered -> no further rf_we, busy=0, lsu_ready=1 once rst_n is high.

Source files
------------

// File: rtl/regfile_writeback_ctrl_if.sv
// Bundle of issue, ALU, LSU and register-file write-port signals for regfile_writeback_ctrl.
// With WB_PERF_CNT_EN defined, the bundle also carries the two performance counters.
interface regfile_writeback_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                       iss_valid;
  logic [ADDR_WIDTH-1:0]      iss_rs1;
  logic [ADDR_WIDTH-1:0]      iss_rs2;
  logic [ADDR_WIDTH-1:0]      iss_rd;
  logic                       iss_stall;
  logic                       alu_valid;
  logic [ADDR_WIDTH-1:0]      alu_rd;
  logic [DATA_WIDTH-1:0]      alu_data;
  // LSU handshake: a transfer happens at a rising edge where lsu_valid && lsu_ready;
  // the producer holds lsu_rd/lsu_data stable while lsu_valid is high and not accepted.
  logic                       lsu_valid;
  logic                       lsu_ready;
  logic [ADDR_WIDTH-1:0]      lsu_rd;
  logic [DATA_WIDTH-1:0]      lsu_data;
  logic                       rf_we;
  logic [ADDR_WIDTH-1:0]      rf_waddr;
  logic [DATA_WIDTH-1:0]      rf_wdata;
  logic [2**ADDR_WIDTH-1:0]   busy;
`ifdef WB_PERF_CNT_EN
  logic [31:0]                perf_stall_cycles;
  logic [31:0]                perf_lsu_bp_cycles;
`endif

  modport master (
`ifdef WB_PERF_CNT_EN
    output perf_stall_cycles, perf_lsu_bp_cycles,
`endif
    input  iss_valid, iss_rs1, iss_rs2, iss_rd,
    output iss_stall,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
`ifdef WB_PERF_CNT_EN
    input  perf_stall_cycles, perf_lsu_bp_cycles,
`endif
    output iss_valid, iss_rs1, iss_rs2, iss_rd,
    input  iss_stall,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// Writeback merger for the 2R/1W register file: ALU (fixed priority) plus buffered LSU, with a
// per-register busy scoreboard driving the issue stall. Optional counters under WB_PERF_CNT_EN.
module regfile_writeback_ctrl #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_writeback_ctrl_if.master bus
);
  localparam int NREG  = 2**ADDR_WIDTH;
  localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_rd   [LSU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  alu_win;

  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;
  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;

  assign full  = (count == (PTR_W+1)'(LSU_FIFO_DEPTH));
  assign empty = (count == '0);

  assign bus.lsu_ready = rst_n && !full;
  // LSU loads to x0 complete the handshake but never enter the buffer.
  assign push    = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != '0);
  assign alu_win = bus.alu_valid && (bus.alu_rd != '0);
  assign pop     = !empty && !alu_win;

  // busy_q[0] is held at 0, so x0 source/destination terms never stall.
  assign bus.iss_stall = rst_n && bus.iss_valid &&
                         (busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] | busy_q[bus.iss_rd]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lsu_rd;
      fifo_data[wr_ptr] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear first so that a reservation at the same edge and index wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
    if (bus.iss_valid && !bus.iss_stall && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      rf_we_q <= alu_win || pop;
      if (alu_win) begin
        rf_waddr_q <= bus.alu_rd;
        rf_wdata_q <= bus.alu_data;
      end else if (pop) begin
        rf_waddr_q <= fifo_rd[rd_ptr];
        rf_wdata_q <= fifo_data[rd_ptr];
      end
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy     = busy_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_bp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_bp_q    <= '0;
    end else begin
      if (bus.iss_stall)                    perf_stall_q <= perf_stall_q + 32'd1;
      if (bus.lsu_valid && !bus.lsu_ready)  perf_bp_q    <= perf_bp_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles  = perf_stall_q;
  assign bus.perf_lsu_bp_cycles = perf_bp_q;
`endif
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: directed scenarios plus randomized traffic checked against
// a queue/array reference model of the writeback and scoreboard rules.
module tb_regfile_writeback_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int NREG  = 2**AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  regfile_writeback_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_writeback_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSU_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NREG-1:0]  busy_m = '0;
  logic             m_we = 1'b0;
  logic [AW-1:0]    m_waddr = '0;
  logic [DW-1:0]    m_wdata = '0;
  logic [AW+DW-1:0] lsu_q[$];
  logic [AW+DW-1:0] exp_q[$];
  int unsigned      m_perf_stall = 0;
  int unsigned      m_perf_bp = 0;

  function automatic logic exp_ready();
    return rst_n && (lsu_q.size() < DEPTH);
  endfunction

  function automatic logic exp_stall();
    return rst_n && bus.iss_valid &&
           (busy_m[bus.iss_rs1] || busy_m[bus.iss_rs2] || busy_m[bus.iss_rd]);
  endfunction

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied, then step the clock.
  task automatic tick();
    logic          rdy, stl, nwe;
    logic [AW-1:0] na;
    logic [DW-1:0] nd;
    rdy = exp_ready();
    stl = exp_stall();
    if (!rst_n) begin
      busy_m = '0; lsu_q.delete(); exp_q.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      m_perf_stall = 0; m_perf_bp = 0;
    end else begin
      if (stl) m_perf_stall++;
      if (bus.lsu_valid && !rdy) m_perf_bp++;
      nwe = 1'b0; na = '0; nd = '0;
      if (bus.alu_valid && bus.alu_rd != 0) begin
        nwe = 1'b1; na = bus.alu_rd; nd = bus.alu_data;
      end else if (lsu_q.size() != 0) begin
        {na, nd} = lsu_q.pop_front();
        nwe = 1'b1;
      end
      if (bus.lsu_valid && rdy && bus.lsu_rd != 0) lsu_q.push_back({bus.lsu_rd, bus.lsu_data});
      if (m_we) busy_m[m_waddr] = 1'b0;
      if (bus.iss_valid && !stl && bus.iss_rd != 0) busy_m[bus.iss_rd] = 1'b1;
      m_we = nwe;
      if (nwe) begin
        m_waddr = na; m_wdata = nd;
        exp_q.push_back({na, nd});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd3; bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2;
    #1;
    checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", bus.iss_stall); end
    checks++; if (bus.lsu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", bus.lsu_ready); end
    tick(); tick();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== '0) begin failures++; $display("FAIL reset_waddr: got %0d want 0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== '0) begin failures++; $display("FAIL reset_wdata: got %h want 0", bus.rf_wdata); end
    checks++; if (bus.busy !== '0) begin failures++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
    rst_n = 1'b1;
    idle();
    #1;
    checks++; if (bus.lsu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after: got %b want 1", bus.lsu_ready); end
  endtask

  task automatic test_alu_write();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    idle();
    #1;
    checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL alu_we: got %b want 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5) begin failures++; $display("FAIL alu_waddr: got %0d want 5", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wdata: got %h want deadbeef", bus.rf_wdata); end
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL alu_we_pulse: got %b want 0", bus.rf_we); end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL sb_issue_stall: got %b want 0", bus.iss_stall); end
    tick();
    checks++; if (bus.busy[7] !== 1'b1) begin failures++; $display("FAIL sb_busy7_set: got %b want 1", bus.busy[7]); end
    bus.iss_rs1 = 5'd7; bus.iss_rd = 5'd8;
    #1;
    checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL sb_raw_stall: got %b want 1", bus.iss_stall); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7) begin failures++; $display("FAIL sb_commit7: got we=%b addr=%0d want we=1 addr=7", bus.rf_we, bus.rf_waddr); end
    checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_commit_cycle: got %b want 1", bus.iss_stall); end
    tick();
    checks++; if (bus.busy[7] !== 1'b0) begin failures++; $display("FAIL sb_busy7_clear: got %b want 0", bus.busy[7]); end
    checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL sb_stall_release: got %b want 0", bus.iss_stall); end
    tick();
    idle();
    #1;
    checks++; if (bus.busy[8] !== 1'b1) begin failures++; $display("FAIL sb_busy8_set: got %b want 1", bus.busy[8]); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h88;
    tick();
    idle();
    tick(); tick();
    checks++; if (bus.busy !== '0) begin failures++; $display("FAIL sb_busy_idle: got %h want 0", bus.busy); end
  endtask

  task automatic test_lsu_starve();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h11;
    #1;
    checks++; if (bus.lsu_ready !== 1'b1) begin failures++; $display("FAIL lsu_ready_push1: got %b want 1", bus.lsu_ready); end
    tick();
    bus.lsu_rd = 5'd4; bus.lsu_data = 32'h22;
    #1;
    checks++; if (bus.lsu_ready !== 1'b1) begin failures++; $display("FAIL lsu_ready_push2: got %b want 1", bus.lsu_ready); end
    tick();
    bus.lsu_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.lsu_ready !== 1'b0) begin failures++; $display("FAIL lsu_ready_full: got %b want 0", bus.lsu_ready); end
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9) begin failures++; $display("FAIL lsu_alu_priority: got we=%b addr=%0d want we=1 addr=9", bus.rf_we, bus.rf_waddr); end
      tick();
    end
    idle();
    tick();
    checks++; if (bus.lsu_ready !== 1'b1) begin failures++; $display("FAIL lsu_ready_drain: got %b want 1", bus.lsu_ready); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h11) begin failures++; $display("FAIL lsu_first: got we=%b addr=%0d data=%h want 1/3/11", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h22) begin failures++; $display("FAIL lsu_second: got we=%b addr=%0d data=%h want 1/4/22", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL lsu_drained: got %b want 0", bus.rf_we); end
  endtask

  task automatic test_alu_x0();
    idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h55;
    tick();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hBAD;
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL x0_no_early_we: got %b want 0", bus.rf_we); end
    tick();
    idle();
    #1;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd2 || bus.rf_wdata !== 32'h55) begin failures++; $display("FAIL x0_fifo_write: got we=%b addr=%0d data=%h want 1/2/55", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tick();
    checks++; if (bus.rf_we !== 1'b0 || bus.busy[0] !== 1'b0) begin failures++; $display("FAIL x0_after: got we=%b busy0=%b want 0/0", bus.rf_we, bus.busy[0]); end
  endtask

  task automatic test_same_edge();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    tick();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
    #1;
    checks++; if (bus.rf_we !== 1'b1 || bus.iss_stall !== 1'b0) begin failures++; $display("FAIL same_setup: got we=%b stall=%b want 1/0", bus.rf_we, bus.iss_stall); end
    tick();
    idle();
    #1;
    checks++; if (bus.busy[6] !== 1'b1) begin failures++; $display("FAIL same_edge_set_wins: got %b want 1", bus.busy[6]); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h67;
    tick();
    idle();
    tick();
    checks++; if (bus.busy[6] !== 1'b0) begin failures++; $display("FAIL same_edge_clear: got %b want 0", bus.busy[6]); end
  endtask

  task automatic test_reset_midop();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd13;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'hA1;
    tick();
    bus.iss_valid = 1'b0;
    bus.lsu_rd = 5'd12; bus.lsu_data = 32'hA2;
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.lsu_ready !== 1'b0 || bus.busy[13] !== 1'b1) begin failures++; $display("FAIL midrst_setup: got ready=%b busy13=%b want 0/1", bus.lsu_ready, bus.busy[13]); end
    rst_n = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd13;
    #1;
    checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL midrst_stall: got %b want 0", bus.iss_stall); end
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    checks++; if (bus.busy !== '0 || bus.lsu_ready !== 1'b1) begin failures++; $display("FAIL midrst_state: got busy=%h ready=%b want 0/1", bus.busy, bus.lsu_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL midrst_no_write: cycle %0d got %b want 0", i, bus.rf_we); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [AW+DW-1:0] w;
    idle();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.alu_valid = ($urandom_range(0, 2) == 0);
      bus.alu_rd    = AW'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      bus.lsu_valid = $urandom_range(0, 1);
      bus.lsu_rd    = AW'($urandom_range(0, 7));
      bus.lsu_data  = $urandom;
      bus.iss_valid = $urandom_range(0, 1);
      bus.iss_rs1   = AW'($urandom_range(0, 7));
      bus.iss_rs2   = AW'($urandom_range(0, 7));
      bus.iss_rd    = AW'($urandom_range(0, 7));
      #1;
      checks++; if (bus.iss_stall !== exp_stall()) begin failures++; $display("FAIL rand_stall: cycle %0d got %b want %b", i, bus.iss_stall, exp_stall()); end
      checks++; if (bus.lsu_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready: cycle %0d got %b want %b", i, bus.lsu_ready, exp_ready()); end
      checks++; if (bus.rf_we !== m_we) begin failures++; $display("FAIL rand_we: cycle %0d got %b want %b", i, bus.rf_we, m_we); end
      checks++; if (bus.busy !== busy_m) begin failures++; $display("FAIL rand_busy: cycle %0d got %h want %h", i, bus.busy, busy_m); end
      if (bus.rf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_unexpected_write: cycle %0d addr=%0d data=%h", i, bus.rf_waddr, bus.rf_wdata);
        end else begin
          w = exp_q.pop_front();
          if ({bus.rf_waddr, bus.rf_wdata} !== w) begin failures++; $display("FAIL rand_write: cycle %0d got %0d/%h want %0d/%h", i, bus.rf_waddr, bus.rf_wdata, w[AW+DW-1:DW], w[DW-1:0]); end
        end
      end
`ifdef WB_PERF_CNT_EN
      checks++; if (bus.perf_stall_cycles !== m_perf_stall) begin failures++; $display("FAIL rand_perf_stall: got %0d want %0d", bus.perf_stall_cycles, m_perf_stall); end
      checks++; if (bus.perf_lsu_bp_cycles !== m_perf_bp) begin failures++; $display("FAIL rand_perf_bp: got %0d want %0d", bus.perf_lsu_bp_cycles, m_perf_bp); end
`endif
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_write();
    test_scoreboard();
    test_lsu_starve();
    test_alu_x0();
    test_same_edge();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
